// File: rtl/nic_cmd_arbiter.sv
// Round-robin share of one NIC command port; each issued command is tagged with an outstanding-table slot
// and its completion is routed back. Grant -> cmd_valid_o one cycle later; a stalled output stage blocks new grants.
module nic_cmd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int CMD_W           = 128,
    parameter int ID_W            = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
    input  logic [NUM_REQ*ID_W-1:0]  req_id_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [CMD_W-1:0]         cmd_o,
    output logic [TAG_W-1:0]         cmd_tag_o,
    input  logic                     cmd_resp_valid_i,
    input  logic [TAG_W-1:0]         cmd_resp_tag_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    output logic [ID_W-1:0]          resp_id_o,
    output logic [TAG_W:0]           inflight_o,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_e;

    stage_e                     state_q, state_d;
    logic [CMD_W-1:0]           cmd_q, cmd_d;
    logic [TAG_W-1:0]           tag_q, tag_d;
    logic [SRC_W-1:0]           rr_q, rr_d;
    logic [MAX_OUTSTANDING-1:0] slot_vld_q, slot_vld_d;
    logic [SRC_W-1:0]           slot_src_q [MAX_OUTSTANDING];
    logic [SRC_W-1:0]           slot_src_d [MAX_OUTSTANDING];
    logic [ID_W-1:0]            slot_id_q  [MAX_OUTSTANDING];
    logic [ID_W-1:0]            slot_id_d  [MAX_OUTSTANDING];
    logic [TAG_W:0]             inflight_q, inflight_d;
    logic [NUM_REQ-1:0]         resp_vld_q, resp_vld_d;
    logic [ID_W-1:0]            resp_id_q, resp_id_d;
    logic                       err_q, err_d;

    logic             drain, any_free, grant, resp_hit, win_found;
    logic [SRC_W-1:0] win, cand;
    logic [TAG_W-1:0] free_idx;

    // Winner search starts at the RR pointer and wraps.
    always_comb begin
        win       = rr_q;
        cand      = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = SRC_W'((int'(rr_q) + i) % NUM_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // Allocation only sees slots free at the start of the cycle; a same-cycle response frees one for next cycle.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int s = MAX_OUTSTANDING - 1; s >= 0; s--) begin
            if (!slot_vld_q[s]) begin
                free_idx = TAG_W'(s);
                any_free = 1'b1;
            end
        end
    end

    assign drain    = (state_q == ST_FULL) && cmd_ready_i;
    assign grant    = rst_ni && ((state_q == ST_EMPTY) || drain) && any_free && win_found;
    assign resp_hit = cmd_resp_valid_i && slot_vld_q[cmd_resp_tag_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            cmd_q      <= '0;
            tag_q      <= '0;
            rr_q       <= '0;
            slot_vld_q <= '0;
            inflight_q <= '0;
            resp_vld_q <= '0;
            resp_id_q  <= '0;
            err_q      <= 1'b0;
            for (int s = 0; s < MAX_OUTSTANDING; s++) begin
                slot_src_q[s] <= '0;
                slot_id_q[s]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tag_q      <= tag_d;
            rr_q       <= rr_d;
            slot_vld_q <= slot_vld_d;
            slot_src_q <= slot_src_d;
            slot_id_q  <= slot_id_d;
            inflight_q <= inflight_d;
            resp_vld_q <= resp_vld_d;
            resp_id_q  <= resp_id_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = ST_FULL;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        cmd_valid_o = (state_q == ST_FULL);
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[win] = 1'b1;
        end
    end

    always_comb begin
        cmd_d      = cmd_q;
        tag_d      = tag_q;
        rr_d       = rr_q;
        slot_vld_d = slot_vld_q;
        slot_src_d = slot_src_q;
        slot_id_d  = slot_id_q;
        resp_vld_d = '0;
        resp_id_d  = resp_id_q;
        err_d      = cmd_resp_valid_i && !slot_vld_q[cmd_resp_tag_i];
        inflight_d = inflight_q + {{TAG_W{1'b0}}, grant} - {{TAG_W{1'b0}}, resp_hit};
        if (resp_hit) begin
            slot_vld_d[cmd_resp_tag_i]             = 1'b0;
            resp_vld_d[slot_src_q[cmd_resp_tag_i]] = 1'b1;
            resp_id_d                              = slot_id_q[cmd_resp_tag_i];
        end
        if (grant) begin
            cmd_d                = req_cmd_i[win*CMD_W +: CMD_W];
            tag_d                = free_idx;
            rr_d                 = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
            slot_vld_d[free_idx] = 1'b1;
            slot_src_d[free_idx] = win;
            slot_id_d[free_idx]  = req_id_i[win*ID_W +: ID_W];
        end
    end

    assign cmd_o        = cmd_q;
    assign cmd_tag_o    = tag_q;
    assign resp_valid_o = resp_vld_q;
    assign resp_id_o    = resp_id_q;
    assign inflight_o   = inflight_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q == ST_FULL) || (inflight_q != '0);

endmodule

// File: tb/tb_nic_cmd_arbiter.sv
// Bench for nic_cmd_arbiter: directed scenarios with a negedge monitor feeding command/response scoreboards.
`timescale 1ns/1ps
module tb_nic_cmd_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CMD_W   = 128;
    localparam int ID_W    = 8;
    localparam int MAX_OUT = 8;
    localparam int TAG_W   = 3;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b1;
    logic [NUM_REQ-1:0]       req_valid_i = '0;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*CMD_W-1:0] req_cmd_i = '0;
    logic [NUM_REQ*ID_W-1:0]  req_id_i = '0;
    logic                     cmd_valid_o;
    logic                     cmd_ready_i = 1'b0;
    logic [CMD_W-1:0]         cmd_o;
    logic [TAG_W-1:0]         cmd_tag_o;
    logic                     cmd_resp_valid_i = 1'b0;
    logic [TAG_W-1:0]         cmd_resp_tag_i = '0;
    logic [NUM_REQ-1:0]       resp_valid_o;
    logic [ID_W-1:0]          resp_id_o;
    logic [TAG_W:0]           inflight_o;
    logic                     busy_o;
    logic                     err_o;

    nic_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_cmd_i(req_cmd_i), .req_id_i(req_id_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_o(cmd_o), .cmd_tag_o(cmd_tag_o),
        .cmd_resp_valid_i(cmd_resp_valid_i), .cmd_resp_tag_i(cmd_resp_tag_i),
        .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .inflight_o(inflight_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [CMD_W-1:0] cmd; logic [TAG_W-1:0] tag; } cexp_t;
    typedef struct packed { logic [NUM_REQ-1:0] oh; logic [ID_W-1:0] id; } rexp_t;

    cexp_t cq[$];
    rexp_t rq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    logic [MAX_OUT-1:0] tb_used = '0;
    int                 tb_src [MAX_OUT];
    logic [ID_W-1:0]    tb_id  [MAX_OUT];
    int                 mon_gnt, mon_tag;
    cexp_t              mon_c;
    rexp_t              mon_r;

    // Monitor: records what each grant/response should produce, using pre-edge values.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            tb_used = '0;
            cq.delete();
            rq.delete();
        end else begin
            mon_gnt = -1;
            for (int r = NUM_REQ - 1; r >= 0; r--) if (req_ready_o[r] && req_valid_i[r]) mon_gnt = r;
            mon_tag = 0;
            for (int s = MAX_OUT - 1; s >= 0; s--) if (!tb_used[s]) mon_tag = s;
            if (cmd_valid_o && cmd_ready_i && cq.size() > 0) void'(cq.pop_front());
            if (cmd_resp_valid_i && tb_used[cmd_resp_tag_i]) begin
                mon_r = '0;
                mon_r.oh[tb_src[cmd_resp_tag_i]] = 1'b1;
                mon_r.id = tb_id[cmd_resp_tag_i];
                rq.push_back(mon_r);
                tb_used[cmd_resp_tag_i] = 1'b0;
            end
            if (mon_gnt >= 0) begin
                mon_c.cmd = req_cmd_i[mon_gnt*CMD_W +: CMD_W];
                mon_c.tag = TAG_W'(mon_tag);
                cq.push_back(mon_c);
                tb_src[mon_tag]  = mon_gnt;
                tb_id[mon_tag]   = req_id_i[mon_gnt*ID_W +: ID_W];
                tb_used[mon_tag] = 1'b1;
            end
        end
    end

    function automatic logic [CMD_W-1:0] fair_cmd(input int r);
        logic [CMD_W-1:0] v;
        v = '0;
        v[127:112] = 16'hF00D;
        v[7:0]     = 8'(r);
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int r, input logic [CMD_W-1:0] c, input logic [ID_W-1:0] id);
        req_cmd_i[r*CMD_W +: CMD_W] = c;
        req_id_i[r*ID_W +: ID_W]    = id;
    endtask

    task automatic apply_reset();
        req_valid_i = '0; cmd_ready_i = 1'b0; cmd_resp_valid_i = 1'b0; cmd_resp_tag_i = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({cmd_valid_o, cmd_o, cmd_tag_o, req_ready_o, resp_valid_o, resp_id_o, inflight_o, busy_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%b cmd=%h tag=%0d rdy=%b rvld=%b rid=%h infl=%0d busy=%b err=%b, required all 0",
                     cmd_valid_o, cmd_o, cmd_tag_o, req_ready_o, resp_valid_o, resp_id_o, inflight_o, busy_o, err_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        n_checks++;
        if (busy_o !== 1'b0 || inflight_o !== '0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b inflight=%0d, required 0/0", busy_o, inflight_o);
        end
    endtask

    task automatic test_single();
        apply_reset(); step();
        set_req(2, 128'hDEAD, 8'h5A);
        req_valid_i = 4'b0100; cmd_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b required 0100", req_ready_o); end
        step();
        req_valid_i = '0;
        #1;
        n_checks++;
        if (cmd_valid_o !== 1'b1 || cmd_tag_o !== 3'd0 || cmd_o !== 128'hDEAD || req_ready_o !== 4'b0000 || inflight_o !== 4'd1) begin
            n_fail++;
            $display("FAIL single_cmd: vld=%b tag=%0d cmd=%h rdy=%b infl=%0d, required 1/0/dead/0000/1",
                     cmd_valid_o, cmd_tag_o, cmd_o, req_ready_o, inflight_o);
        end
        step();
        n_checks++;
        if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: vld=%b required 0", cmd_valid_o); end
        cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = 3'd0;
        step();
        cmd_resp_valid_i = 1'b0;
        n_checks++;
        if (rq.size() == 0) begin
            n_fail++; $display("FAIL single_resp: got rvld=%b rid=%h with no expectation queued", resp_valid_o, resp_id_o);
        end else begin
            if (resp_valid_o !== rq[0].oh || resp_id_o !== rq[0].id || resp_valid_o !== 4'b0100 || resp_id_o !== 8'h5A) begin
                n_fail++; $display("FAIL single_resp: rvld=%b rid=%h, required 0100/5a", resp_valid_o, resp_id_o);
            end
            void'(rq.pop_front());
        end
        n_checks++;
        if (inflight_o !== 4'd0) begin n_fail++; $display("FAIL single_inflight: got %0d required 0", inflight_o); end
        step();
        n_checks++;
        if (resp_valid_o !== 4'b0000 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: rvld=%b busy=%b, required 0000/0", resp_valid_o, busy_o);
        end
    endtask

    task automatic test_fairness();
        apply_reset(); step();
        cmd_ready_i = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_req(r, fair_cmd(r), 8'(8'h10 + r));
        for (int k = 0; k < 20; k++) begin
            req_valid_i = (k < 16) ? '1 : '0;
            cmd_resp_valid_i = 1'b0;
            if (k >= 1 && k <= 16) begin
                n_checks++;
                if (cmd_valid_o !== 1'b1 || cmd_o !== fair_cmd((k - 1) % NUM_REQ)) begin
                    n_fail++; $display("FAIL fair_order k=%0d: vld=%b cmd=%h, required 1/%h", k, cmd_valid_o, cmd_o, fair_cmd((k - 1) % NUM_REQ));
                end
            end
            if (cmd_valid_o) begin
                n_checks++;
                if (cq.size() == 0) begin
                    n_fail++; $display("FAIL fair_sb_cmd k=%0d: got tag=%0d with no expectation queued", k, cmd_tag_o);
                end else begin
                    if (cmd_o !== cq[0].cmd || cmd_tag_o !== cq[0].tag) begin
                        n_fail++; $display("FAIL fair_sb_cmd k=%0d: cmd=%h tag=%0d, required %h/%0d", k, cmd_o, cmd_tag_o, cq[0].cmd, cq[0].tag);
                    end
                    cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = cq[0].tag;
                end
            end
            if (resp_valid_o != '0) begin
                n_checks++;
                if (rq.size() == 0) begin
                    n_fail++; $display("FAIL fair_sb_resp k=%0d: rvld=%b with no expectation queued", k, resp_valid_o);
                end else begin
                    if (resp_valid_o !== rq[0].oh || resp_id_o !== rq[0].id) begin
                        n_fail++; $display("FAIL fair_sb_resp k=%0d: rvld=%b rid=%h, required %b/%h", k, resp_valid_o, resp_id_o, rq[0].oh, rq[0].id);
                    end
                    void'(rq.pop_front());
                end
            end
            #1;
            if (k < 16) begin
                n_checks++;
                if (req_ready_o !== (4'b0001 << (k % NUM_REQ))) begin
                    n_fail++; $display("FAIL fair_grant k=%0d: rdy=%b required %b", k, req_ready_o, 4'b0001 << (k % NUM_REQ));
                end
            end
            step();
        end
        n_checks++;
        if (cq.size() != 0 || rq.size() != 0 || inflight_o !== '0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL fair_end: cq=%0d rq=%0d infl=%0d busy=%b, required 0/0/0/0", cq.size(), rq.size(), inflight_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(); step();
        set_req(0, 128'hA0, 8'h01);
        set_req(1, 128'hA1, 8'h02);
        req_valid_i = 4'b0011; cmd_ready_i = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL bp_first: rdy=%b required 0001", req_ready_o); end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (cmd_valid_o !== 1'b1 || cmd_o !== 128'hA0 || cmd_tag_o !== 3'd0 || req_ready_o !== 4'b0000) begin
                n_fail++; $display("FAIL bp_hold i=%0d: vld=%b cmd=%h tag=%0d rdy=%b, required 1/a0/0/0000", i, cmd_valid_o, cmd_o, cmd_tag_o, req_ready_o);
            end
            step();
        end
        cmd_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0010 || cmd_o !== 128'hA0) begin
            n_fail++; $display("FAIL bp_release: rdy=%b cmd=%h, required 0010/a0", req_ready_o, cmd_o);
        end
        step();
        req_valid_i = '0;
        n_checks++;
        if (cmd_valid_o !== 1'b1 || cmd_o !== 128'hA1 || cmd_tag_o !== 3'd1) begin
            n_fail++; $display("FAIL bp_next: vld=%b cmd=%h tag=%0d, required 1/a1/1", cmd_valid_o, cmd_o, cmd_tag_o);
        end
        step();
        n_checks++;
        if (cmd_valid_o !== 1'b0 || inflight_o !== 4'd2) begin
            n_fail++; $display("FAIL bp_end: vld=%b infl=%0d, required 0/2", cmd_valid_o, inflight_o);
        end
    endtask

    task automatic test_table_full();
        apply_reset(); step();
        cmd_ready_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            set_req(3, CMD_W'(32'hB000 + k), 8'(8'h30 + k));
            req_valid_i = 4'b1000;
            n_checks++;
            if ((k >= 1 && k <= 8) ? (cmd_valid_o !== 1'b1 || cmd_tag_o !== 3'(k - 1)) : (cmd_valid_o !== 1'b0)) begin
                n_fail++; $display("FAIL full_tag k=%0d: vld=%b tag=%0d", k, cmd_valid_o, cmd_tag_o);
            end
            if (cmd_valid_o) begin
                n_checks++;
                if (cq.size() == 0) begin
                    n_fail++; $display("FAIL full_sb_cmd k=%0d: got tag=%0d with no expectation queued", k, cmd_tag_o);
                end else if (cmd_o !== cq[0].cmd || cmd_tag_o !== cq[0].tag) begin
                    n_fail++; $display("FAIL full_sb_cmd k=%0d: cmd=%h tag=%0d, required %h/%0d", k, cmd_o, cmd_tag_o, cq[0].cmd, cq[0].tag);
                end
            end
            #1;
            n_checks++;
            if (req_ready_o !== ((k < 8) ? 4'b1000 : 4'b0000)) begin
                n_fail++; $display("FAIL full_ready k=%0d: rdy=%b required %b", k, req_ready_o, (k < 8) ? 4'b1000 : 4'b0000);
            end
            step();
        end
        n_checks++;
        if (inflight_o !== 4'd8 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL full_inflight: infl=%0d busy=%b, required 8/1", inflight_o, busy_o);
        end
        cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = 3'd3;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL full_free_late: rdy=%b required 0000", req_ready_o); end
        step();
        cmd_resp_valid_i = 1'b0;
        set_req(3, 128'hBEEF, 8'h3F);
        n_checks++;
        if (resp_valid_o !== 4'b1000 || resp_id_o !== 8'h33 || inflight_o !== 4'd7) begin
            n_fail++; $display("FAIL full_resp3: rvld=%b rid=%h infl=%0d, required 1000/33/7", resp_valid_o, resp_id_o, inflight_o);
        end
        #1;
        n_checks++;
        if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL full_regrant: rdy=%b required 1000", req_ready_o); end
        step();
        req_valid_i = '0;
        n_checks++;
        if (cmd_valid_o !== 1'b1 || cmd_tag_o !== 3'd3 || cmd_o !== 128'hBEEF || inflight_o !== 4'd8) begin
            n_fail++; $display("FAIL full_reuse: vld=%b tag=%0d cmd=%h infl=%0d, required 1/3/beef/8", cmd_valid_o, cmd_tag_o, cmd_o, inflight_o);
        end
    endtask

    // Continues from the full table left by test_table_full.
    task automatic test_same_cycle();
        step();
        cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = 3'd7;
        step();
        cmd_resp_valid_i = 1'b0;
        n_checks++;
        if (inflight_o !== 4'd7 || resp_valid_o !== 4'b1000 || resp_id_o !== 8'h37) begin
            n_fail++; $display("FAIL same_setup: infl=%0d rvld=%b rid=%h, required 7/1000/37", inflight_o, resp_valid_o, resp_id_o);
        end
        set_req(3, 128'hCAFE, 8'h77);
        req_valid_i = 4'b1000;
        cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = 3'd0;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL same_grant: rdy=%b required 1000", req_ready_o); end
        step();
        req_valid_i = '0; cmd_resp_valid_i = 1'b0;
        n_checks++;
        if (cmd_valid_o !== 1'b1 || cmd_tag_o !== 3'd7 || cmd_o !== 128'hCAFE || inflight_o !== 4'd7 ||
            resp_valid_o !== 4'b1000 || resp_id_o !== 8'h30) begin
            n_fail++; $display("FAIL same_alloc: vld=%b tag=%0d cmd=%h infl=%0d rvld=%b rid=%h, required 1/7/cafe/7/1000/30",
                               cmd_valid_o, cmd_tag_o, cmd_o, inflight_o, resp_valid_o, resp_id_o);
        end
        step();
        n_checks++;
        if (cmd_valid_o !== 1'b0 || inflight_o !== 4'd7 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL same_end: vld=%b infl=%0d busy=%b, required 0/7/1", cmd_valid_o, inflight_o, busy_o);
        end
    endtask

    task automatic test_err_reset();
        apply_reset(); step();
        cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = 3'd6;
        step();
        cmd_resp_valid_i = 1'b0;
        n_checks++;
        if (err_o !== 1'b1 || resp_valid_o !== 4'b0000) begin
            n_fail++; $display("FAIL err_free_slot: err=%b rvld=%b, required 1/0000", err_o, resp_valid_o);
        end
        step();
        n_checks++;
        if (err_o !== 1'b0 || inflight_o !== 4'd0) begin
            n_fail++; $display("FAIL err_pulse: err=%b infl=%0d, required 0/0", err_o, inflight_o);
        end
        for (int r = 0; r < 3; r++) set_req(r, CMD_W'(32'hE000 + r), 8'(8'h40 + r));
        req_valid_i = 4'b0111; cmd_ready_i = 1'b1;
        repeat (3) step();
        req_valid_i = '0;
        n_checks++;
        if (inflight_o !== 4'd3 || cmd_valid_o !== 1'b1 || cmd_o !== CMD_W'(32'hE002)) begin
            n_fail++; $display("FAIL err_inflight3: infl=%0d vld=%b cmd=%h, required 3/1/e002", inflight_o, cmd_valid_o, cmd_o);
        end
        req_valid_i = 4'b1000;
        #1 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({cmd_valid_o, cmd_o, cmd_tag_o, req_ready_o, resp_valid_o, resp_id_o, inflight_o, busy_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL err_async_reset: vld=%b cmd=%h tag=%0d rdy=%b rvld=%b rid=%h infl=%0d busy=%b err=%b, required all 0",
                     cmd_valid_o, cmd_o, cmd_tag_o, req_ready_o, resp_valid_o, resp_id_o, inflight_o, busy_o, err_o);
        end
        req_valid_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        cmd_resp_valid_i = 1'b1; cmd_resp_tag_i = 3'd0;
        step();
        cmd_resp_valid_i = 1'b0;
        n_checks++;
        if (err_o !== 1'b1 || resp_valid_o !== 4'b0000 || inflight_o !== 4'd0) begin
            n_fail++; $display("FAIL err_after_reset: err=%b rvld=%b infl=%0d, required 1/0000/0", err_o, resp_valid_o, inflight_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t, required finish before 100000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_table_full();
        test_same_cycle();
        test_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
